// File: rtl/lightsaber_color_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lightsaber_pkg
//
// Shared types for the lightsaber color sequencing controller: the blade
// state enumeration, the color channel width and the packed {r,g,b} color
// struct, plus a small helper that tells whether a state is a ramp state.
//
// No ports (package). Imported by the interface, the channel ramp and the
// top level.
// ---------------------------------------------------------------------------
package lightsaber_pkg;

    localparam int COLOR_W = 8;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_IGNITE  = 3'd1,
        ST_ON      = 3'd2,
        ST_FADE    = 3'd3,
        ST_RETRACT = 3'd4
    } state_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    // A ramp state is one where the color registers are moving toward a goal
    // and the blade is reported busy.
    function automatic logic isRampState(input state_t s);
        return (s == ST_IGNITE) || (s == ST_FADE) || (s == ST_RETRACT);
    endfunction

endpackage

// File: rtl/lightsaber_color_ctrl_if.sv
// ---------------------------------------------------------------------------
// lightsaber_color_ctrl_if
//
// Groups the controller's request side (power level, target color
// handshake) and its color-register side (enable, R/G/B, busy).
//
// Signals:
//   power      master->slave  blade power request, level
//   tgt_valid  master->slave  new target color offered
//   tgt_ready  slave->master  controller accepts a target this cycle
//   tgt_r/g/b  master->slave  offered target color (8 bits each)
//   en_o       slave->master  enable to the color registers
//   r_o/g_o/b_o slave->master current color to the color registers
//   busy       slave->master  a ramp (ignite/fade/retract) is in progress
//
// Modports: master (user-input / mode logic side), slave (controller).
// ---------------------------------------------------------------------------
interface lightsaber_color_ctrl_if;
    import lightsaber_pkg::*;

    logic               power;
    logic               tgt_valid;
    logic               tgt_ready;
    logic [COLOR_W-1:0] tgt_r;
    logic [COLOR_W-1:0] tgt_g;
    logic [COLOR_W-1:0] tgt_b;
    logic               en_o;
    logic [COLOR_W-1:0] r_o;
    logic [COLOR_W-1:0] g_o;
    logic [COLOR_W-1:0] b_o;
    logic               busy;

    modport master (
        output power, tgt_valid, tgt_r, tgt_g, tgt_b,
        input  tgt_ready, en_o, r_o, g_o, b_o, busy
    );

    modport slave (
        input  power, tgt_valid, tgt_r, tgt_g, tgt_b,
        output tgt_ready, en_o, r_o, g_o, b_o, busy
    );

endinterface

// File: rtl/lightsaber_color_ctrl_channel_ramp.sv
// ---------------------------------------------------------------------------
// channel_ramp
//
// One color channel's stepping logic. On a tick the channel moves toward its
// goal by at most i_step, landing exactly on the goal rather than passing it,
// and never wrapping around the 8-bit range. Without a tick it holds.
//
// Ports:
//   i_cur     current registered channel value
//   i_goal    value the channel is heading toward
//   i_step    largest change allowed in one tick
//   i_tick    step enable
//   o_next    value to register next
//   o_atGoal  current value already equals the goal
// ---------------------------------------------------------------------------
module channel_ramp
    import lightsaber_pkg::*;
(
    input  logic [COLOR_W-1:0] i_cur,
    input  logic [COLOR_W-1:0] i_goal,
    input  logic [COLOR_W-1:0] i_step,
    input  logic               i_tick,
    output logic [COLOR_W-1:0] o_next,
    output logic               o_atGoal
);

    logic               w_up;
    logic [COLOR_W-1:0] w_dist;
    logic [COLOR_W-1:0] w_delta;

    // The step is clamped to the remaining distance, so the sum or
    // difference below always stays between cur and goal and can neither
    // overshoot nor wrap.
    always_comb begin
        w_up     = (i_goal > i_cur);
        w_dist   = w_up ? (i_goal - i_cur) : (i_cur - i_goal);
        w_delta  = (w_dist < i_step) ? w_dist : i_step;
        o_next   = i_cur;
        o_atGoal = (i_cur == i_goal);
        if (i_tick) begin
            o_next = w_up ? (i_cur + w_delta) : (i_cur - w_delta);
        end
    end

endmodule

// File: rtl/lightsaber_color_ctrl.sv
// ---------------------------------------------------------------------------
// lightsaber_color_ctrl
//
// Sequencing controller for the lightsaber color registers. Owns the
// power-on ignition ramp, mid-use color fades and power-off retraction, and
// drives enable plus 8-bit R/G/B into the color register block every cycle.
// New target colors arrive over a valid/ready handshake, accepted only while
// the blade is OFF or steadily ON.
//
// Parameters:
//   DIV        clock cycles per ramp step (>=1)
//   STEP       largest per-channel change per step (1..255)
//   RESET_RGB  target color {R,G,B} loaded at reset
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    lightsaber_color_ctrl_if.slave (power, target handshake,
//          enable, color outputs, busy)
//
// Build option: define LIGHTSABER_FADE_EN for gradual DIV/STEP ramps.
// Without it every ramp jumps to its goal in the first cycle of the ramp
// state and the ramp state lasts exactly two cycles (jump, then check).
// ---------------------------------------------------------------------------
module lightsaber_color_ctrl
    import lightsaber_pkg::*;
#(
    parameter int                     DIV       = 4,
    parameter int                     STEP      = 16,
    parameter logic [3*COLOR_W-1:0]   RESET_RGB = 24'h0000FF
)(
    input  logic                   clk,
    input  logic                   rst_n,
    lightsaber_color_ctrl_if.slave bus
);

`ifdef LIGHTSABER_FADE_EN
    localparam bit FADE_EN = 1'b1;
`else
    localparam bit FADE_EN = 1'b0;
`endif

    localparam int                 TICK_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(DIV - 1);
    // A step of all-ones covers any distance, which turns each ramp into a
    // single jump when gradual fading is built out.
    localparam logic [COLOR_W-1:0] STEP_SIZE = FADE_EN ? COLOR_W'(STEP)
                                                       : {COLOR_W{1'b1}};

    state_t             r_state;
    state_t             w_nextState;
    logic [TICK_W-1:0]  r_tick;
    logic [TICK_W-1:0]  w_tickNext;
    rgb_t               r_cur;
    rgb_t               r_target;
    rgb_t               w_goal;
    logic               r_en;
    logic               r_busy;

    logic               w_isRamp;
    logic               w_ready;
    logic               w_accept;
    logic               w_tick;
    logic               w_checkOk;
    logic               w_allAtGoal;
    logic [2:0]         w_atGoal;
    logic [COLOR_W-1:0] w_nextR;
    logic [COLOR_W-1:0] w_nextG;
    logic [COLOR_W-1:0] w_nextB;

    // The handshake is open only while the blade is idle (OFF) or steady
    // (ON); tgt_ready depends on the state register alone.
    always_comb begin
        w_isRamp = isRampState(r_state);
        w_ready  = (r_state == ST_OFF) || (r_state == ST_ON);
        w_accept = bus.tgt_valid && w_ready;
    end

    // The ramp goal is the stored target while igniting or fading, black
    // while retracting, and the current value elsewhere so nothing moves.
    always_comb begin
        w_goal = r_cur;
        case (r_state)
            ST_IGNITE, ST_FADE: w_goal = r_target;
            ST_RETRACT:         w_goal = '0;
            default:            w_goal = r_cur;
        endcase
    end

    // Step pacing. With fading, the counter free-runs 0..DIV-1 inside a ramp
    // state and steps on the wrap. Without fading, the step happens on the
    // first cycle of the ramp state and the counter then parks at 1, which
    // holds off the completion check until the second cycle.
    always_comb begin
        w_tick     = 1'b0;
        w_checkOk  = 1'b1;
        w_tickNext = '0;
        if (FADE_EN) begin
            w_tick     = w_isRamp && (r_tick == TICK_LAST);
            w_checkOk  = 1'b1;
            w_tickNext = (w_isRamp && !w_tick) ? (r_tick + 1'b1) : '0;
        end else begin
            w_tick     = w_isRamp && (r_tick == '0);
            w_checkOk  = (r_tick != '0);
            w_tickNext = w_isRamp ? TICK_W'(1) : '0;
        end
    end

    channel_ramp uRampR (
        .i_cur    (r_cur.r),
        .i_goal   (w_goal.r),
        .i_step   (STEP_SIZE),
        .i_tick   (w_tick),
        .o_next   (w_nextR),
        .o_atGoal (w_atGoal[2])
    );

    channel_ramp uRampG (
        .i_cur    (r_cur.g),
        .i_goal   (w_goal.g),
        .i_step   (STEP_SIZE),
        .i_tick   (w_tick),
        .o_next   (w_nextG),
        .o_atGoal (w_atGoal[1])
    );

    channel_ramp uRampB (
        .i_cur    (r_cur.b),
        .i_goal   (w_goal.b),
        .i_step   (STEP_SIZE),
        .i_tick   (w_tick),
        .o_next   (w_nextB),
        .o_atGoal (w_atGoal[0])
    );

    assign w_allAtGoal = &w_atGoal;

    // Next-state decode. Losing power beats every other transition in
    // IGNITE/ON/FADE; regaining power during RETRACT re-ignites from the
    // current color. Completion looks at the registered color, so a state
    // is left one cycle after its final step lands.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_OFF: begin
                if (bus.power) w_nextState = ST_IGNITE;
            end
            ST_IGNITE, ST_FADE: begin
                if (!bus.power)                    w_nextState = ST_RETRACT;
                else if (w_allAtGoal && w_checkOk) w_nextState = ST_ON;
            end
            ST_ON: begin
                if (!bus.power)    w_nextState = ST_RETRACT;
                else if (w_accept) w_nextState = ST_FADE;
            end
            ST_RETRACT: begin
                if (bus.power)                     w_nextState = ST_IGNITE;
                else if (w_allAtGoal && w_checkOk) w_nextState = ST_OFF;
            end
            default: w_nextState = ST_OFF;
        endcase
    end

    // State, pacing counter, color and target registers. The counter
    // restarts on every state entry. Enable and busy are registered from the
    // next state so they change together with the state itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_OFF;
            r_tick   <= '0;
            r_cur    <= '0;
            r_target <= RESET_RGB;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_tick   <= (w_nextState != r_state) ? '0 : w_tickNext;
            r_cur    <= '{r: w_nextR, g: w_nextG, b: w_nextB};
            if (w_accept) begin
                r_target <= '{r: bus.tgt_r, g: bus.tgt_g, b: bus.tgt_b};
            end
            r_en     <= (w_nextState != ST_OFF);
            r_busy   <= isRampState(w_nextState);
        end
    end

    assign bus.tgt_ready = w_ready;
    assign bus.en_o      = r_en;
    assign bus.busy      = r_busy;
    assign bus.r_o       = r_cur.r;
    assign bus.g_o       = r_cur.g;
    assign bus.b_o       = r_cur.b;

endmodule
